// File: rtl/systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl
//   Job controller for a PE_ARRAY_H x PE_ARRAY_W weight-stationary systolic
//   array. A job has four phases:
//     1. It loads PE_ARRAY_H weight rows into the columns.
//     2. It pops the loaded weights into the active registers.
//     3. It feeds i_num_vec activation vectors through a diagonal skew chain.
//     4. It drains the array. o_done marks the last drain cycle.
//
// Optional build macro:
//   STC_CTRL_STALL_CNT_EN  enables the saturating FEED stall counter on
//                          o_stall_cnt. Without it, o_stall_cnt is tied to 0.
//
// Ports:
//   clk, rst       single clock, asynchronous active-low reset
//   i_start        starts a job (only seen in IDLE); i_num_vec is latched then
//   i_num_vec      number of activation vectors in the job (0 skips FEED)
//   o_busy/o_done  job in progress / one-cycle pulse on the final DRAIN cycle
//   i_w_*/o_w_rdy  weight-row stream (one row of PE_ARRAY_W elements per beat)
//   i_a_*/o_a_rdy  activation-vector stream (PE_ARRAY_H elements per beat)
//   o_load_*       per-column weight load strobe, row id and element
//   o_pop_vld      per-column weight pop, one pulse after the last load beat
//   o_left_data    skewed activations into the left edge of each row
//   o_res_vld      per-column result-valid, the accept strobe delayed
//   o_stall_cnt    FEED cycles without an activation handshake
// -----------------------------------------------------------------------------
module systolic_array_ctrl #(
  parameter int PE_ARRAY_W    = 4,
  parameter int PE_ARRAY_H    = 4,
  parameter int IN_DATA_WIDTH = 8,
  parameter int RES_LAT       = PE_ARRAY_H + 1,
  localparam int ID_W         = (PE_ARRAY_H > 1) ? $clog2(PE_ARRAY_H) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start,
  input  logic [15:0]                         i_num_vec,
  output logic                                o_busy,
  output logic                                o_done,
  input  logic                                i_w_vld,
  output logic                                o_w_rdy,
  input  logic [PE_ARRAY_W*IN_DATA_WIDTH-1:0] i_w_data,
  input  logic                                i_a_vld,
  output logic                                o_a_rdy,
  input  logic [PE_ARRAY_H*IN_DATA_WIDTH-1:0] i_a_data,
  output logic [PE_ARRAY_W-1:0]               o_load_vld,
  output logic [PE_ARRAY_W*ID_W-1:0]          o_load_id,
  output logic [PE_ARRAY_W*IN_DATA_WIDTH-1:0] o_load_data,
  output logic [PE_ARRAY_W-1:0]               o_pop_vld,
  output logic [PE_ARRAY_H*IN_DATA_WIDTH-1:0] o_left_data,
  output logic [PE_ARRAY_W-1:0]               o_res_vld,
  output logic [31:0]                         o_stall_cnt
);

  localparam int DL_LEN                  = RES_LAT + PE_ARRAY_W;
  localparam logic [15:0] DRAIN_LAST     = 16'(PE_ARRAY_W + PE_ARRAY_H + RES_LAT - 1);
  localparam logic [ID_W-1:0] ROW_LAST   = ID_W'(PE_ARRAY_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN
  } state_t;

  state_t                          state_q, state_d;
  logic [15:0]                     num_vec_q, num_vec_d;
  logic [ID_W-1:0]                 row_q, row_d;
  logic [15:0]                     vec_q, vec_d;
  logic [15:0]                     drain_q, drain_d;
  logic                            pop_q, pop_d;
  logic                            load_vld_q, load_vld_d;
  logic [ID_W-1:0]                 load_id_q, load_id_d;
  logic [PE_ARRAY_W*IN_DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic [DL_LEN-1:0]               dl_q;

  logic                            w_acc;
  logic                            a_acc;
  logic [PE_ARRAY_H*IN_DATA_WIDTH-1:0] a_inj;

  assign w_acc = (state_q == S_LOAD) && i_w_vld;
  assign a_acc = (state_q == S_FEED) && i_a_vld;
  // A cycle without a handshake pushes zeros into the skew chain.
  assign a_inj = a_acc ? i_a_data : '0;

  always_comb begin
    state_d     = state_q;
    num_vec_d   = num_vec_q;
    row_d       = row_q;
    vec_d       = vec_q;
    drain_d     = drain_q;
    pop_d       = 1'b0;
    load_vld_d  = w_acc;
    load_id_d   = row_q;
    load_data_d = w_acc ? i_w_data : load_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          num_vec_d = i_num_vec;
          row_d     = '0;
          vec_d     = '0;
          drain_d   = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_acc) begin
          if (row_q == ROW_LAST) begin
            pop_d   = 1'b1;
            state_d = (num_vec_q == 16'd0) ? S_DRAIN : S_FEED;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_FEED: begin
        // Compare against num_vec-1 so 65535 completes without the count wrapping.
        if (a_acc) begin
          if (vec_q == num_vec_q - 16'd1) state_d = S_DRAIN;
          else                            vec_d   = vec_q + 16'd1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_IDLE;
        else                       drain_d = drain_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      num_vec_q   <= '0;
      row_q       <= '0;
      vec_q       <= '0;
      drain_q     <= '0;
      pop_q       <= 1'b0;
      load_vld_q  <= 1'b0;
      load_id_q   <= '0;
      load_data_q <= '0;
      dl_q        <= '0;
    end else begin
      state_q     <= state_d;
      num_vec_q   <= num_vec_d;
      row_q       <= row_d;
      vec_q       <= vec_d;
      drain_q     <= drain_d;
      pop_q       <= pop_d;
      load_vld_q  <= load_vld_d;
      load_id_q   <= load_id_d;
      load_data_q <= load_data_d;
      dl_q        <= {dl_q[DL_LEN-2:0], a_acc};
    end
  end

  // Skew chain: row h has h+1 stages. The newest element enters at the bottom
  // slice, and the top slice drives the array edge.
  for (genvar h = 0; h < PE_ARRAY_H; h++) begin : g_skew
    logic [(h+1)*IN_DATA_WIDTH-1:0] sk_q;
    if (h == 0) begin : g_first
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sk_q <= '0;
        else      sk_q <= a_inj[IN_DATA_WIDTH-1:0];
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) sk_q <= '0;
        else      sk_q <= {sk_q[h*IN_DATA_WIDTH-1:0], a_inj[h*IN_DATA_WIDTH +: IN_DATA_WIDTH]};
      end
    end
    assign o_left_data[h*IN_DATA_WIDTH +: IN_DATA_WIDTH] = sk_q[h*IN_DATA_WIDTH +: IN_DATA_WIDTH];
  end

`ifdef STC_CTRL_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && i_start)
      stall_d = '0;
    else if ((state_q == S_FEED) && !a_acc && (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = '0;
`endif

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DRAIN) && (drain_q == DRAIN_LAST);
  assign o_w_rdy     = (state_q == S_LOAD);
  assign o_a_rdy     = (state_q == S_FEED);
  assign o_load_vld  = {PE_ARRAY_W{load_vld_q}};
  assign o_load_id   = {PE_ARRAY_W{load_id_q}};
  assign o_load_data = load_data_q;
  assign o_pop_vld   = {PE_ARRAY_W{pop_q}};
  // Column j sees the accept strobe 1+RES_LAT+j cycles later.
  // dl_q[k] holds the strobe from k+1 cycles back.
  assign o_res_vld   = dl_q[RES_LAT +: PE_ARRAY_W];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_array_ctrl
//   Scoreboard bench for systolic_array_ctrl (W=H=4, 8-bit data).
//   The driver pushes the expected (cycle, value) events when it drives the
//   stimulus. A negedge monitor pops and compares them as the outputs appear.
//   In any cycle with no expected event, the monitored outputs must be 0.
// -----------------------------------------------------------------------------
module tb_systolic_array_ctrl;

  localparam int W         = 4;
  localparam int H         = 4;
  localparam int DW        = 8;
  localparam int IDW       = 2;
  localparam int RL        = H + 1;
  localparam int DRAIN_LEN = W + H + RL;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              i_start   = 1'b0;
  logic [15:0]       i_num_vec = '0;
  logic              i_w_vld   = 1'b0;
  logic [W*DW-1:0]   i_w_data  = '0;
  logic              i_a_vld   = 1'b0;
  logic [H*DW-1:0]   i_a_data  = '0;
  logic              o_busy, o_done, o_w_rdy, o_a_rdy;
  logic [W-1:0]      o_load_vld, o_pop_vld, o_res_vld;
  logic [W*IDW-1:0]  o_load_id;
  logic [W*DW-1:0]   o_load_data;
  logic [H*DW-1:0]   o_left_data;
  logic [31:0]       o_stall_cnt;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0]     c;
    logic [IDW-1:0]  id;
    logic [W*DW-1:0] d;
  } ld_t;

  typedef struct packed {
    logic [31:0]   c;
    logic [DW-1:0] v;
  } lv_t;

  ld_t ld_q[$];
  int  pop_q[$];
  int  done_q[$];
  int  res_q[W][$];
  lv_t lv_q[H][$];
  ld_t mon_ld;
  lv_t mon_lv;

  systolic_array_ctrl #(
    .PE_ARRAY_W(W),
    .PE_ARRAY_H(H),
    .IN_DATA_WIDTH(DW),
    .RES_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst_n),
    .i_start(i_start), .i_num_vec(i_num_vec), .o_busy(o_busy), .o_done(o_done),
    .i_w_vld(i_w_vld), .o_w_rdy(o_w_rdy), .i_w_data(i_w_data),
    .i_a_vld(i_a_vld), .o_a_rdy(o_a_rdy), .i_a_data(i_a_data),
    .o_load_vld(o_load_vld), .o_load_id(o_load_id), .o_load_data(o_load_data),
    .o_pop_vld(o_pop_vld), .o_left_data(o_left_data), .o_res_vld(o_res_vld),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (ld_q.size() > 0 && ld_q[0].c == cyc) begin
      mon_ld = ld_q.pop_front();
      check("load_vld",  o_load_vld,  {W{1'b1}});
      check("load_id",   o_load_id,   {W{mon_ld.id}});
      check("load_data", o_load_data, mon_ld.d);
    end else begin
      check("load_vld_idle", o_load_vld, '0);
    end

    if (pop_q.size() > 0 && pop_q[0] == cyc) begin
      void'(pop_q.pop_front());
      check("pop_vld", o_pop_vld, {W{1'b1}});
    end else begin
      check("pop_vld_idle", o_pop_vld, '0);
    end

    if (done_q.size() > 0 && done_q[0] == cyc) begin
      void'(done_q.pop_front());
      check("done", o_done, 1);
    end else begin
      check("done_idle", o_done, 0);
    end

    for (int j = 0; j < W; j++) begin
      if (res_q[j].size() > 0 && res_q[j][0] == cyc) begin
        void'(res_q[j].pop_front());
        check($sformatf("res_vld[%0d]", j), o_res_vld[j], 1);
      end else begin
        check($sformatf("res_vld_idle[%0d]", j), o_res_vld[j], 0);
      end
    end

    for (int h = 0; h < H; h++) begin
      if (lv_q[h].size() > 0 && lv_q[h][0].c == cyc) begin
        mon_lv = lv_q[h].pop_front();
        check($sformatf("left_data[%0d]", h), o_left_data[h*DW +: DW], mon_lv.v);
      end else begin
        check($sformatf("left_bubble[%0d]", h), o_left_data[h*DW +: DW], '0);
      end
    end
  end

  task automatic flush_sb;
    ld_q.delete();
    pop_q.delete();
    done_q.delete();
    for (int j = 0; j < W; j++) res_q[j].delete();
    for (int h = 0; h < H; h++) lv_q[h].delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"},   {o_busy, o_done, o_w_rdy, o_a_rdy, o_load_vld, o_pop_vld, o_res_vld}, '0);
    check({tag, "_left"},  o_left_data, '0);
    check({tag, "_load"},  {o_load_id, o_load_data}, '0);
    check({tag, "_stall"}, o_stall_cnt, '0);
  endtask

  function automatic logic [W*DW-1:0] w_row(input int r);
    logic [W*DW-1:0] d;
    for (int j = 0; j < W; j++) d[j*DW +: DW] = 8'((r + 1) | (j << 4));
    return d;
  endfunction

  function automatic logic [DW-1:0] a_elem(input int k, input int h);
    return 8'(k * H + h + 1);
  endfunction

  // nv vectors. stall_len bubbles are placed before vector stall_at.
  // A nonzero hold keeps i_start high for the whole job.
  // abort_at >= 0 resets the DUT once that many vectors are accepted.
  task automatic run_job(input int nv, input int stall_at, input int stall_len,
                         input bit hold, input int abort_at);
    int k;
    int st;
    int done_cyc;
    int exp_stall;
    logic [H*DW-1:0] v;

    i_start   = 1'b1;
    i_num_vec = 16'(nv);
    tick;
    if (!hold) i_start = 1'b0;
    i_num_vec = ~16'(nv);
    check("busy_load", o_busy, 1);
    check("w_rdy_load", o_w_rdy, 1);

    for (int r = 0; r < H; r++) begin
      i_w_vld  = 1'b1;
      i_w_data = w_row(r);
      ld_q.push_back('{c: 32'(cyc + 1), id: IDW'(r), d: w_row(r)});
      if (r == H - 1) pop_q.push_back(cyc + 1);
      tick;
    end
    i_w_vld  = 1'b0;
    i_w_data = '0;

    k  = 0;
    st = 0;
    while (k < nv) begin
      if (abort_at >= 0 && k == abort_at) begin
        rst_n   = 1'b0;
        i_a_vld = 1'b0;
        i_start = 1'b0;
        #1;
        check_all_zero("abort");
        flush_sb();
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        return;
      end
      if (k == stall_at && st < stall_len) begin
        i_a_vld  = 1'b0;
        i_a_data = $urandom;
        st++;
      end else begin
        for (int h = 0; h < H; h++) begin
          v[h*DW +: DW] = a_elem(k, h);
          lv_q[h].push_back('{c: 32'(cyc + 1 + h), v: a_elem(k, h)});
        end
        for (int j = 0; j < W; j++) res_q[j].push_back(cyc + 1 + RL + j);
        i_a_vld  = 1'b1;
        i_a_data = v;
        k++;
      end
      tick;
    end
    i_a_vld  = 1'b0;
    i_a_data = '0;

    // cyc is now the first DRAIN cycle.
    done_cyc = cyc + DRAIN_LEN - 1;
    done_q.push_back(done_cyc);
    while (cyc <= done_cyc + 1) begin
      if (cyc == done_cyc) begin
        check("busy_last_drain", o_busy, 1);
        i_start = 1'b0;
      end
      if (cyc == done_cyc + 1) check("busy_after_done", o_busy, 0);
      tick;
    end

`ifdef STC_CTRL_STALL_CNT_EN
    exp_stall = stall_len;
`else
    exp_stall = 0;
`endif
    check("stall_cnt", o_stall_cnt, 64'(exp_stall));
    check("sb_done_empty", done_q.size(), 0);
    check("sb_pop_empty", pop_q.size(), 0);
    check("sb_load_empty", ld_q.size(), 0);
    for (int j = 0; j < W; j++) check($sformatf("sb_res_empty[%0d]", j), res_q[j].size(), 0);
    for (int h = 0; h < H; h++) check($sformatf("sb_left_empty[%0d]", h), lv_q[h].size(), 0);
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    check("idle_busy", o_busy, 0);

    run_job(2, -1, 0, 1'b0, -1);       // load ids 0..3, skew of {1,2,3,4},{5,6,7,8}
    run_job(3, 1, 2, 1'b0, -1);        // two bubbles mid-stream
    run_job(0, -1, 0, 1'b0, -1);       // FEED bypassed
    run_job(2, -1, 0, 1'b1, -1);       // i_start held through job
    run_job(5, -1, 0, 1'b0, 2);        // reset during FEED
    run_job(3, 0, 1, 1'b0, -1);        // job after abort; stall count restarts
    run_job(3, -1, 0, 1'b0, -1);       // stall count cleared at job start
    run_job(65535, -1, 0, 1'b0, -1);   // largest vector count

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_array_ctrl.md
SYSTOLIC_ARRAY_CTRL -- requirements
Module: systolic_array_ctrl

Interface
REQ-001 SHALL have parameter PE_ARRAY_W, default 4: array columns.
REQ-002 SHALL have parameter PE_ARRAY_H, default 4: array rows, and the number of weight beats per job.
REQ-003 SHALL have parameter IN_DATA_WIDTH, default 8: weight and activation element width.
REQ-004 SHALL have parameter RES_LAT, default PE_ARRAY_H+1: cycles from a column-0 feed to its column-0 result.
REQ-005 SHALL have ports clk in 1 (single clock) and rst in 1 (asynchronous, active-low).
REQ-006 SHALL have ports i_start in 1, i_num_vec in 16, o_busy out 1, o_done out 1: job control.
REQ-007 SHALL have ports i_w_vld in 1, o_w_rdy out 1, i_w_data in PE_ARRAY_W*IN_DATA_WIDTH: weight-row stream.
REQ-008 SHALL have ports i_a_vld in 1, o_a_rdy out 1, i_a_data in PE_ARRAY_H*IN_DATA_WIDTH: activation-vector stream.
REQ-009 SHALL have ports o_load_vld[W] out 1, o_load_id[W] out $clog2(PE_ARRAY_H), o_load_data[W] out IN_DATA_WIDTH: per-column weight load.
REQ-010 SHALL have ports o_pop_vld[W] out 1, o_left_data[H] out IN_DATA_WIDTH, o_res_vld[W] out 1, o_stall_cnt out 32.

Function
REQ-011 SHALL implement FSM IDLE->LOAD->FEED->DRAIN->IDLE.
REQ-012 SHALL ignore i_start unless in IDLE; in IDLE, i_start SHALL latch i_num_vec and enter LOAD.
REQ-013 SHALL hold o_busy=1 in every state except IDLE.
REQ-014 In LOAD, o_w_rdy SHALL be 1, and each accepted beat (i_w_vld&o_w_rdy) SHALL drive o_load_vld[j]=1, o_load_data[j]=i_w_data slice j, and o_load_id[j]=row counter, registered with 1-cycle latency.
REQ-015 The row counter SHALL start at 0, count to PE_ARRAY_H-1, then leave LOAD; no beats SHALL be accepted outside LOAD.
REQ-016 On LOAD exit, all o_pop_vld[j] SHALL pulse for exactly 1 cycle.
REQ-017 In FEED, o_a_rdy SHALL be 1 until num_vec vectors are accepted; element h of each accepted vector SHALL appear on o_left_data[h] after 1+h cycles (skew chain).
REQ-018 A FEED cycle without a handshake SHALL inject a zero bubble into the skew chain and increment the stall count.
REQ-019 num_vec=0 SHALL bypass FEED: LOAD->DRAIN.
REQ-020 o_res_vld[j] SHALL equal the accepted-vector strobe delayed 1+RES_LAT+j cycles; bubbles SHALL NOT produce o_res_vld.
REQ-021 DRAIN SHALL last PE_ARRAY_W+PE_ARRAY_H+RES_LAT cycles and then return to IDLE, with o_done pulsed 1 cycle on the final DRAIN cycle.
REQ-022 The counters SHALL be 16-bit with no wrap: num_vec=65535 SHALL complete normally.

Reset
REQ-023 Asserting rst (low) SHALL asynchronously force IDLE and clear all counters, the skew chain and the delay lines.
REQ-024 During reset, all outputs SHALL be 0; rst asserted mid-job SHALL abort the job with no o_done.

Configuration
REQ-025 With STC_CTRL_STALL_CNT_EN defined, o_stall_cnt SHALL count FEED stall cycles; it SHALL clear at job start and saturate at 2^32-1.
REQ-026 Without STC_CTRL_STALL_CNT_EN, o_stall_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-027 Scenario: W=H=4, weight rows 0x01..0x04 with no stalls -> o_load_id[*] sequence 0,1,2,3, load_data column 0 = 0x01,0x02,0x03,0x04, then one o_pop_vld pulse.
REQ-028 Scenario: num_vec=2, vectors {1,2,3,4},{5,6,7,8} -> o_left_data[3] carries 4 at cycle t+4 and 8 at cycle t+5, where t is the first accept cycle.
REQ-029 Scenario: num_vec=3 with i_a_vld low for 2 cycles mid-stream -> zeros injected, o_stall_cnt=2 (macro on) or 0 (macro off), exactly 3 o_res_vld[0] pulses.
REQ-030 Scenario: num_vec=0 -> LOAD, pop, DRAIN of 13 cycles, o_done pulse, no o_res_vld.
REQ-031 Scenario: i_start held high during a job -> ignored, only one o_done per job.
REQ-032 Scenario: rst low during FEED -> all outputs 0 immediately and o_busy=0; a new job then runs correctly.
